uart_tx_buffer: RTL and testbench

Byte FIFO and pacing engine that sits directly upstream of the CPU's UART transmitter. It accepts bytes from the CPU store path in single-cycle pushes, buffers up to DEPTH of them, and issues them one at a time to the transmitter as a one-cycle `uart_wr_o` strobe with stable data. The transmitter exposes no busy flag, so the buffer enforces a fixed minimum spacing between strobes that covers one full transmitter frame.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_buffer.sv | 112 +++++++++++
 tb/tb_uart_tx_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   pacer_state_e  : states of the transmit pacer (IDLE, ISSUE, GAP).
//   FRAME_BITS     : bits per transmitter frame (start + 8 data + parity + stop).
//   min_gap_cycles : smallest legal strobe spacing for a given bit period.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } pacer_state_e;

  // The transmitter has no busy flag, so strobes must be at least one
  // full frame apart.
  function automatic int unsigned min_gap_cycles(input int unsigned clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Parameterised single-clock FIFO.
//   clk_i, rstn_i   : clock, asynchronous active-low reset
//   push_i/push_dat_i : write request and data; ignored while full
//   pop_i           : read request; ignored while empty
//   rd_dat_o        : entry at the read pointer (valid when !empty_o)
//   full_o, empty_o, level_o : occupancy derived from the registered count
// Full/empty are judged on the registered count, so a push while full is
// dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o   = (count_q == LW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign level_o  = count_q;
  assign rd_dat_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count marks which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and pacing engine in front of the UART transmitter.
//   sys_clk_i, sys_rstn_i : clock, asynchronous active-low reset
//   push_i/push_dat_i     : single-cycle byte push from the CPU
//   clr_ovf_i             : clears the sticky overflow flag
//   full_o/empty_o/level_o: FIFO occupancy
//   ovf_o                 : sticky, set when a push was dropped
//   uart_wr_o/uart_dat_o  : one-cycle write strobe and held data
//   dbg_state_o           : current pacer state
// The pacer issues one byte, then waits GAP_CYCLES cycles (strobe edge to
// strobe edge) before the next, covering one transmitter frame.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int GAP_CYCLES = 1024,
  localparam int LW         = $clog2(DEPTH) + 1,
  localparam int CW         = $clog2(GAP_CYCLES)
) (
  input  logic          sys_clk_i,
  input  logic          sys_rstn_i,
  input  logic          push_i,
  input  logic [7:0]    push_dat_i,
  input  logic          clr_ovf_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o,
  output logic          ovf_o,
  output logic          uart_wr_o,
  output logic [7:0]    uart_dat_o,
  output pacer_state_e  dbg_state_o
);

  pacer_state_e  state_q, state_d;
  logic          uart_wr_q, uart_wr_d;
  logic [7:0]    uart_dat_q, uart_dat_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic [7:0]    fifo_rd_dat;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (sys_clk_i),
    .rstn_i     (sys_rstn_i),
    .push_i     (push_i),
    .push_dat_i (push_dat_i),
    .pop_i      (pop),
    .rd_dat_o   (fifo_rd_dat),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o)
  );

  // The pop lands on the same edge that registers the strobe.
  assign pop = (state_q == ST_ISSUE);

  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (push_i && full_o) ovf_d = 1'b1;
    else if (clr_ovf_i)   ovf_d = 1'b0;
  end

  // GAP loads GAP_CYCLES-2: with the ISSUE cycle and the terminal-count
  // cycle this gives exactly GAP_CYCLES between strobe rising edges.
  always_comb begin
    state_d    = state_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_o) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        uart_wr_d  = 1'b1;
        uart_dat_d = fifo_rd_dat;
        gap_cnt_d  = CW'(GAP_CYCLES - 2);
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = empty_o ? ST_IDLE : ST_ISSUE;
        else                 gap_cnt_d = gap_cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q    <= ST_IDLE;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
      gap_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      gap_cnt_q  <= gap_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign uart_wr_o   = uart_wr_q;
  assign uart_dat_o  = uart_dat_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer. The reference model keeps the buffered bytes in
// a queue and decides strobe timing from two rules: a strobe needs data
// present two edges earlier and at least GAP cycles since the previous one.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          push = 1'b0;
  logic [7:0]    push_dat = 8'h00;
  logic          clr = 1'b0;
  logic          full, empty, ovf, uart_wr;
  logic [LW-1:0] level;
  logic [7:0]    uart_dat;
  pacer_state_e  dbg_state;

  uart_tx_buffer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .push_i     (push),
    .push_dat_i (push_dat),
    .clr_ovf_i  (clr),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .ovf_o      (ovf),
    .uart_wr_o  (uart_wr),
    .uart_dat_o (uart_dat),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic [7:0] exp_dat;
  logic       exp_wr;
  bit         have_last;
  int         last_strobe;
  bit         ne_d1, ne_d2;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         seen_cyc[$];
  logic [7:0] seen_dat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0; exp_dat = 8'h00; exp_wr = 1'b0;
    have_last = 1'b0; last_strobe = 0; ne_d1 = 1'b0; ne_d2 = 1'b0;
  endtask

  function automatic bit strobe_next();
    return (!have_last || (cyc + 1 - last_strobe >= GAP)) && ne_d1;
  endfunction

  task automatic check_outputs();
    check("uart_wr", uart_wr, exp_wr);
    check("uart_dat", uart_dat, exp_dat);
    check("level", level, exp_q.size());
    check("empty", empty, exp_q.size() == 0);
    check("full", full, exp_q.size() == DEPTH);
    check("ovf", ovf, m_ovf);
  endtask

  // One clock: the model consumes the inputs present at the edge, then
  // outputs are compared at the falling edge.
  task automatic step();
    bit strobe, full_before;
    @(posedge clk);
    cyc++;
    strobe = (!have_last || (cyc - last_strobe >= GAP)) && ne_d2 && (exp_q.size() != 0);
    full_before = (exp_q.size() == DEPTH);
    if (strobe) begin
      exp_dat = exp_q.pop_front();
      last_strobe = cyc;
      have_last = 1'b1;
    end
    if (push && full_before) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    if (push && !full_before) exp_q.push_back(push_dat);
    exp_wr = strobe;
    ne_d2 = ne_d1;
    ne_d1 = (exp_q.size() != 0);
    @(negedge clk);
    check_outputs();
    if (uart_wr) begin
      seen_cyc.push_back(cyc);
      seen_dat.push_back(uart_dat);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    push = 1'b1; push_dat = b;
    step();
    push = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pcts[4];
    int timed, budget, strobes;
    model_reset();

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_wr", uart_wr, 1'b0);
    check("rst_hold_empty", empty, 1'b1);
    rstn = 1'b1;
    check_outputs();
    check("rst_state", dbg_state, ST_IDLE);
    idle(4);

    // Single byte: strobe exactly two cycles after the push
    seen_cyc.delete(); seen_dat.delete();
    push_byte(8'h41);
    idle(3 * GAP + 2);
    check("single_count", seen_cyc.size(), 1);
    if (seen_cyc.size() == 1) begin
      check("single_dat", seen_dat[0], 8'h41);
      check("single_latency", seen_cyc[0] - (cyc - (3 * GAP + 2)), 2);
    end

    // Burst 30..33: order and spacing
    seen_cyc.delete(); seen_dat.delete();
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    idle(5 * GAP);
    check("burst_count", seen_cyc.size(), 4);
    for (int i = 0; i < 4 && i < seen_cyc.size(); i++) begin
      check("burst_dat", seen_dat[i], 8'h30 + 8'(i));
      if (i > 0) check("burst_spacing", seen_cyc[i] - seen_cyc[i-1], GAP);
    end

    // Overflow while the gap stalls draining, then clear
    for (int i = 0; i < 20; i++) push_byte(8'($urandom_range(0, 255)));
    check("ovf_set", ovf, 1'b1);
    idle(2);
    push = 1'b1; push_dat = 8'hEE; clr = 1'b1;   // dropped push beats clear
    step();
    push = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);
    step();
    clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
    idle(20 * GAP);

    // Wrap with push timed to each strobe edge: level holds across pop+push
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    timed = 0; budget = 0;
    while (timed < 40 && budget < 60 * GAP) begin
      push = strobe_next();
      push_dat = 8'($urandom_range(0, 255));
      if (push) timed++;
      step();
      budget++;
    end
    push = 1'b0;
    check("wrap_timed_pushes", timed, 40);
    idle(6 * GAP);

    // Randomised traffic with varying push density
    pcts[0] = 2; pcts[1] = 5; pcts[2] = 20; pcts[3] = 60;
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      pct = pcts[$urandom_range(0, 3)];
      for (int i = 0; i < 400; i++) begin
        push = ($urandom_range(0, 99) < pct);
        push_dat = 8'($urandom_range(0, 255));
        clr = ($urandom_range(0, 63) == 0);
        step();
      end
    end
    push = 1'b0; clr = 1'b0;
    idle(20 * GAP);

    // Reset on the second strobe cycle with 5 bytes still queued
    seen_cyc.delete(); seen_dat.delete();
    for (int i = 0; i < 7; i++) push_byte(8'h50 + 8'(i));
    budget = 0;
    while (seen_cyc.size() < 2 && budget < 3 * GAP) begin
      step();
      budget++;
    end
    check("midrst_reached", seen_cyc.size(), 2);
    check("midrst_queued", level, 5);
    #2 rstn = 1'b0;
    #1;
    check("midrst_wr", uart_wr, 1'b0);
    check("midrst_dat", uart_dat, 8'h00);
    check("midrst_level", level, 0);
    check("midrst_empty", empty, 1'b1);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    strobes = seen_cyc.size();
    idle(3 * GAP);
    check("midrst_no_strobe", seen_cyc.size(), strobes);
    push_byte(8'h7E);
    idle(GAP);
    check("midrst_restart", seen_cyc.size(), strobes + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
